// File: rtl/mask_bbox_tracker_if.sv
// mask_bbox_tracker_if: binary video stream in, per-frame bounding box results out.
interface mask_bbox_tracker_if #(
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int CW = 20
);
  logic          bin_data;
  logic          bin_de;
  logic          bin_hs;
  logic          bin_vs;
  logic [XW-1:0] x_min;
  logic [XW-1:0] x_max;
  logic [YW-1:0] y_min;
  logic [YW-1:0] y_max;
  logic [CW-1:0] pix_cnt;
  logic          obj_valid;
  logic          frame_done;
  modport master (
    output bin_data, bin_de, bin_hs, bin_vs,
    input  x_min, x_max, y_min, y_max, pix_cnt, obj_valid, frame_done
  );
  modport slave (
    input  bin_data, bin_de, bin_hs, bin_vs,
    output x_min, x_max, y_min, y_max, pix_cnt, obj_valid, frame_done
  );
endinterface

// File: rtl/mask_bbox_tracker.sv
// mask_bbox_tracker: per-frame bounding box and population of mask pixels, published at vsync.
module mask_bbox_tracker #(
  parameter int          XW         = 11,
  parameter int          YW         = 10,
  parameter int          CW         = 20,
  parameter logic        VS_POL     = 1'b1,
  parameter int unsigned MIN_PIXELS = 16
) (
  input logic                 clk,
  input logic                 rst,
  mask_bbox_tracker_if.slave  bus
);
  typedef enum logic {SYNC_WAIT, ACTIVE} state_t;
  state_t        state, state_nx;
  logic          vs_d, de_d, vs_edge, de_fall, hit, close, unused_hs;
  logic [XW-1:0] x_cnt, acc_xmin, acc_xmax;
  logic [YW-1:0] y_cnt, acc_ymin, acc_ymax;
  logic [CW-1:0] acc_cnt;
  assign unused_hs = bus.bin_hs;
  assign vs_edge   = (bus.bin_vs == VS_POL) && (vs_d != VS_POL);
  assign de_fall   = ~bus.bin_de && de_d;
  // a pixel coinciding with the frame boundary belongs to neither frame
  assign hit       = (state == ACTIVE) && bus.bin_de && bus.bin_data && !vs_edge;
  assign close     = (state == ACTIVE) && vs_edge;
  always_comb begin
    state_nx = vs_edge ? ACTIVE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC_WAIT;
    else     state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d     <= ~VS_POL;
      de_d     <= 1'b0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else begin
      vs_d     <= bus.bin_vs;
      de_d     <= bus.bin_de;
      x_cnt    <= (vs_edge || de_fall) ? '0 : (bus.bin_de && ~&x_cnt) ? x_cnt + XW'(1) : x_cnt;
      y_cnt    <= vs_edge ? '0 : (de_fall && ~&y_cnt) ? y_cnt + YW'(1) : y_cnt;
      acc_xmin <= vs_edge ? '1 : (hit && x_cnt < acc_xmin) ? x_cnt : acc_xmin;
      acc_xmax <= vs_edge ? '0 : (hit && x_cnt > acc_xmax) ? x_cnt : acc_xmax;
      acc_ymin <= vs_edge ? '1 : (hit && y_cnt < acc_ymin) ? y_cnt : acc_ymin;
      acc_ymax <= vs_edge ? '0 : (hit && y_cnt > acc_ymax) ? y_cnt : acc_ymax;
      acc_cnt  <= vs_edge ? '0 : (hit && ~&acc_cnt) ? acc_cnt + CW'(1) : acc_cnt;
    end
  end
  // an empty frame reports a zero box rather than the inverted accumulator sentinels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.x_min      <= '0;
      bus.x_max      <= '0;
      bus.y_min      <= '0;
      bus.y_max      <= '0;
      bus.pix_cnt    <= '0;
      bus.obj_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= close;
      if (close) begin
        bus.pix_cnt   <= acc_cnt;
        bus.obj_valid <= 32'(acc_cnt) >= MIN_PIXELS;
        bus.x_min     <= (acc_cnt != '0) ? acc_xmin : '0;
        bus.x_max     <= (acc_cnt != '0) ? acc_xmax : '0;
        bus.y_min     <= (acc_cnt != '0) ? acc_ymin : '0;
        bus.y_max     <= (acc_cnt != '0) ? acc_ymax : '0;
      end
    end
  end
endmodule

// File: tb/tb_mask_bbox_tracker.sv
// tb_mask_bbox_tracker: directed frames driven into three differently parameterised trackers.
module tb_mask_bbox_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data = 1'b0, de = 1'b0, hs = 1'b0, vs = 1'b0;
  int   checks = 0, errors = 0, fd1 = 0, fdb;
  always #5 clk = ~clk;
  mask_bbox_tracker_if #(.XW(11), .YW(10), .CW(20)) if1 ();
  mask_bbox_tracker_if #(.XW(11), .YW(10), .CW(20)) if16 ();
  mask_bbox_tracker_if #(.XW(3),  .YW(10), .CW(4))  ifc ();
  assign if1.bin_data  = data;
  assign if1.bin_de    = de;
  assign if1.bin_hs    = hs;
  assign if1.bin_vs    = vs;
  assign if16.bin_data = data;
  assign if16.bin_de   = de;
  assign if16.bin_hs   = hs;
  assign if16.bin_vs   = vs;
  assign ifc.bin_data  = data;
  assign ifc.bin_de    = de;
  assign ifc.bin_hs    = hs;
  assign ifc.bin_vs    = vs;
  mask_bbox_tracker #(.MIN_PIXELS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mask_bbox_tracker dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  mask_bbox_tracker #(.XW(3), .CW(4), .MIN_PIXELS(1)) dutc (.clk(clk), .rst(rst), .bus(ifc.slave));
  always @(negedge clk) if (if1.frame_done) fd1++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  // de=0 cycles carry data=1 so that ignored blanking data is exercised too
  task automatic line(input int w, input logic [15:0] m);
    for (int x = 0; x < w; x++) begin
      @(negedge clk); de = 1'b1; data = m[x];
    end
    @(negedge clk); de = 1'b0; data = 1'b1;
    repeat (3) @(negedge clk);
    data = 1'b0;
  endtask
  task automatic frame8(input logic [7:0] m0, m1, m2, m3);
    line(8, 16'(m0)); line(8, 16'(m1)); line(8, 16'(m2)); line(8, 16'(m3));
  endtask
  task automatic vs_rise();
    @(negedge clk); vs = 1'b1;
    @(negedge clk);
  endtask
  task automatic vs_end();
    @(negedge clk);
    chk("fd_one_cycle", 32'(if1.frame_done), 0);
    vs = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_xmin", 32'(if1.x_min), 0);
    chk("rst_xmax", 32'(if1.x_max), 0);
    chk("rst_ymin", 32'(if1.y_min), 0);
    chk("rst_ymax", 32'(if1.y_max), 0);
    chk("rst_pix", 32'(if1.pix_cnt), 0);
    chk("rst_valid", 32'(if1.obj_valid), 0);
    chk("rst_fd", 32'(if1.frame_done), 0);
    rst = 1'b0;
    line(8, 16'hFF); line(8, 16'hFF);
    vs_rise();
    chk("sync_no_fd", 32'(if1.frame_done), 0);
    vs_end();
    frame8(8'h00, 8'h00, 8'h00, 8'h00);
    vs_rise();
    chk("f1_fd", 32'(if1.frame_done), 1);
    chk("f1_pix", 32'(if1.pix_cnt), 0);
    chk("f1_xmax", 32'(if1.x_max), 0);
    chk("f1_valid", 32'(if1.obj_valid), 0);
    vs_end();
    frame8(8'h00, 8'h04, 8'h00, 8'h20);
    vs_rise();
    chk("f2_fd", 32'(if1.frame_done), 1);
    chk("f2_xmin", 32'(if1.x_min), 2);
    chk("f2_xmax", 32'(if1.x_max), 5);
    chk("f2_ymin", 32'(if1.y_min), 1);
    chk("f2_ymax", 32'(if1.y_max), 3);
    chk("f2_pix", 32'(if1.pix_cnt), 2);
    chk("f2_valid", 32'(if1.obj_valid), 1);
    chk("f2_pix16", 32'(if16.pix_cnt), 2);
    chk("f2_valid16", 32'(if16.obj_valid), 0);
    vs_end();
    frame8(8'h00, 8'h04, 8'h00, 8'h20);
    chk("hold_xmax", 32'(if1.x_max), 5);
    vs_rise();
    chk("f3_fd", 32'(if1.frame_done), 1);
    chk("f3_pix", 32'(if1.pix_cnt), 2);
    vs_end();
    frame8(8'h00, 8'h00, 8'h00, 8'h00);
    vs_rise();
    chk("empty_pix", 32'(if1.pix_cnt), 0);
    chk("empty_xmin", 32'(if1.x_min), 0);
    chk("empty_ymax", 32'(if1.y_max), 0);
    chk("empty_valid", 32'(if1.obj_valid), 0);
    vs_end();
    frame8(8'hFF, 8'h7F, 8'h00, 8'h00);
    vs_rise();
    chk("p15_pix16", 32'(if16.pix_cnt), 15);
    chk("p15_valid16", 32'(if16.obj_valid), 0);
    chk("p15_xmax", 32'(if1.x_max), 7);
    chk("p15_ymax", 32'(if1.y_max), 1);
    vs_end();
    frame8(8'hFF, 8'hFF, 8'h00, 8'h00);
    vs_rise();
    chk("p16_pix16", 32'(if16.pix_cnt), 16);
    chk("p16_valid16", 32'(if16.obj_valid), 1);
    vs_end();
    line(8, 16'h0); line(8, 16'h0); line(8, 16'h0);
    for (int x = 0; x < 7; x++) begin
      @(negedge clk); de = 1'b1; data = 1'b0;
    end
    @(negedge clk); de = 1'b1; data = 1'b1; vs = 1'b1;
    @(negedge clk); de = 1'b0; data = 1'b0;
    chk("coin_fd", 32'(if1.frame_done), 1);
    chk("coin_pix", 32'(if1.pix_cnt), 0);
    vs_end();
    frame8(8'h00, 8'h00, 8'h00, 8'h00);
    vs_rise();
    chk("coin_next_pix", 32'(if1.pix_cnt), 0);
    vs_end();
    frame8(8'hFF, 8'h00, 8'h00, 8'h00);
    vs_rise();
    chk("pre_rst_pix", 32'(if1.pix_cnt), 8);
    vs_end();
    line(8, 16'hFF);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("mid_rst_pix", 32'(if1.pix_cnt), 0);
    chk("mid_rst_xmax", 32'(if1.x_max), 0);
    chk("mid_rst_valid", 32'(if1.obj_valid), 0);
    @(negedge clk); rst = 1'b0;
    fdb = fd1;
    line(8, 16'hFF);
    vs_rise();
    chk("post_rst_no_fd", 32'(if1.frame_done), 0);
    chk("post_rst_fd_cnt", 32'(fd1), 32'(fdb));
    vs_end();
    frame8(8'hFF, 8'h01, 8'h00, 8'h00);
    vs_rise();
    chk("post_rst_fd", 32'(if1.frame_done), 1);
    chk("post_rst_pix", 32'(if1.pix_cnt), 9);
    chk("post_rst_ymax", 32'(if1.y_max), 1);
    vs_end();
    frame8(8'hFF, 8'hFF, 8'h0F, 8'h00);
    vs_rise();
    chk("sat_pixc", 32'(ifc.pix_cnt), 15);
    chk("sat_pix1", 32'(if1.pix_cnt), 20);
    vs_end();
    line(12, 16'h0400);
    vs_rise();
    chk("xsat_xmaxc", 32'(ifc.x_max), 7);
    chk("xsat_xminc", 32'(ifc.x_min), 7);
    chk("xsat_xmax1", 32'(if1.x_max), 10);
    vs_end();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
